// File: rtl/mux_select_arbiter.sv
// mux_select_arbiter
//   Two-source, packet-aware round-robin arbiter feeding a 2:1 mux. It drives
//   the mux select line and presents the granted source's beat through a
//   single registered output stage with valid/ready handshake. A grant is held
//   until the granted source delivers a beat marked last, so packets from the
//   two sources never interleave.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   in0_valid    source 0 offers a beat
//   in0_data     source 0 beat data
//   in0_last     source 0 beat closes its packet
//   in0_ready    source 0 beat accepted when in0_valid & in0_ready
//   in1_valid    source 1 offers a beat
//   in1_data     source 1 beat data
//   in1_last     source 1 beat closes its packet
//   in1_ready    source 1 beat accepted when in1_valid & in1_ready
//   select_line  index of the source whose beat sits in the output register
//   out_valid    output register holds a beat
//   out_data     output beat data
//   out_last     output beat closes its packet
//   out_ready    downstream accepts the beat when out_valid & out_ready
module mux_select_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in0_valid,
  input  logic [DATA_WIDTH-1:0] in0_data,
  input  logic                  in0_last,
  output logic                  in0_ready,
  input  logic                  in1_valid,
  input  logic [DATA_WIDTH-1:0] in1_data,
  input  logic                  in1_last,
  output logic                  in1_ready,
  output logic                  select_line,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    rr_q, rr_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_last_q, out_last_d;
  logic                    sel_q, sel_d;

  logic                    load_en;
  logic                    grant0, grant1;
  logic                    acc0, acc1;

  // The output register can take a new beat when empty or being drained.
  assign load_en = !out_valid_q || out_ready;

  // Arbitration. rr_q holds the source that completed the last packet, so a
  // tie goes to the other one; rr_q resets to 1 so the first tie favours 0.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case (state_q)
      IDLE: begin
        if (in0_valid && in1_valid) begin
          grant0 = rr_q;
          grant1 = !rr_q;
        end else begin
          grant0 = in0_valid;
          grant1 = in1_valid;
        end
      end
      LOCK0:   grant0 = 1'b1;
      LOCK1:   grant1 = 1'b1;
      default: begin
        grant0 = 1'b0;
        grant1 = 1'b0;
      end
    endcase
  end

  // Readies are masked during reset so nothing is accepted on a reset edge.
  assign in0_ready = grant0 && load_en && !reset;
  assign in1_ready = grant1 && load_en && !reset;
  assign acc0      = in0_valid && in0_ready;
  assign acc1      = in1_valid && in1_ready;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    sel_d       = sel_q;

    if (state_q != IDLE && state_q != LOCK0 && state_q != LOCK1) begin
      state_d = IDLE;
    end

    if (acc0) begin
      out_valid_d = 1'b1;
      out_data_d  = in0_data;
      out_last_d  = in0_last;
      sel_d       = 1'b0;
      if (in0_last) begin
        state_d = IDLE;
        rr_d    = 1'b0;
      end else begin
        state_d = LOCK0;
      end
    end else if (acc1) begin
      out_valid_d = 1'b1;
      out_data_d  = in1_data;
      out_last_d  = in1_last;
      sel_d       = 1'b1;
      if (in1_last) begin
        state_d = IDLE;
        rr_d    = 1'b1;
      end else begin
        state_d = LOCK1;
      end
    end else if (out_ready) begin
      // Drained with nothing new: data, last and select keep their values.
      out_valid_d = 1'b0;
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_q        <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      sel_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      sel_q       <= sel_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign select_line = sel_q;

endmodule
